// File: rtl/bram2reg_loader.sv
// Restores the GPR file from a BRAM image: issues one word read per cycle for
// GPRs 1..NUM_REGS-1 and replays each returned word onto the register-file write port.
module bram2reg_loader #(
  parameter int          DATA_W    = 32,
  parameter int          ADDR_W    = 5,
  parameter int          NUM_REGS  = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              ram_clk,
  output logic              ram_rst,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [ADDR_W-1:0] reg_addr_wr,
  output logic [DATA_W-1:0] reg_wd,
  output logic              reg_we
);

  localparam int IDX_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  logic [1:0]       state;
  logic             start_q;
  logic             start_edge;
  logic [IDX_W-1:0] idx;

  // Read-tracking pipe: stage k holds the read issued k+1 cycles ago, so the
  // last stage lines up with ram_rd_data arriving RD_LAT cycles after issue.
  logic [RD_LAT-1:0] pipe_vld;
  logic [ADDR_W-1:0] pipe_idx [RD_LAT];

  assign ram_clk     = clk;
  assign ram_rst     = rst;
  assign ram_we      = 4'b0000;
  assign ram_wr_data = '0;

  assign start_edge = start_i & ~start_q;
  assign busy_o     = (state == S_ISSUE) || (state == S_DRAIN);
  assign done_o     = (state == S_DONE);

  // start_q resets high so a start_i already asserted across reset is not an edge.
  // NOTE: every sequential block uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      start_q  <= 1'b1;
      idx      <= '0;
      ram_en   <= 1'b0;
      ram_addr <= BASE_ADDR;
    end else begin
      start_q <= start_i;
      case (state)
        S_IDLE: begin
          if (start_edge) begin
            state    <= S_ISSUE;
            idx      <= IDX_W'(1);
            ram_en   <= 1'b1;
            ram_addr <= BASE_ADDR + 32'd4;
          end
        end
        S_ISSUE: begin
          if (idx == LAST_IDX) begin
            state  <= S_DRAIN;
            ram_en <= 1'b0;
          end else begin
            idx      <= idx + IDX_W'(1);
            ram_addr <= ram_addr + 32'd4;
          end
        end
        S_DRAIN: begin
          if (pipe_vld == '0) state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= ram_en;
      for (int k = 1; k < RD_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
    end
  end

  // NOTE: only the valid bits are reset; the index payload is qualified by
  // them, so leaving it unreset keeps the pipe a plain shift register.
  always_ff @(posedge clk) begin
    pipe_idx[0] <= idx[ADDR_W-1:0];
    for (int k = 1; k < RD_LAT; k++) pipe_idx[k] <= pipe_idx[k-1];
  end

  // Write port is registered so reg_we/addr/data are stable for a whole cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_we      <= 1'b0;
      reg_addr_wr <= '0;
      reg_wd      <= '0;
    end else begin
      reg_we <= pipe_vld[RD_LAT-1];
      if (pipe_vld[RD_LAT-1]) begin
        reg_addr_wr <= pipe_idx[RD_LAT-1];
        reg_wd      <= ram_rd_data;
      end
    end
  end

endmodule
